// File: rtl/lock_pkg.sv
// Shared definitions for the lock chamber sequencer and its 7-seg display decoder.
package lock_pkg;

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_ARRIVE = 2'd1;
    localparam logic [1:0] PH_FANDP  = 2'd2;
    localparam logic [1:0] PH_EVAC   = 2'd3;

    // Count widths seen by the display decoder
    localparam int ARRIVE_W = 3;
    localparam int FANDP_W  = 3;
    localparam int EVAC_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = PH_IDLE,
        ST_ARRIVE = PH_ARRIVE,
        ST_FANDP  = PH_FANDP,
        ST_EVAC   = PH_EVAC
    } phase_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while enabled and flags the last count as a tick.
module tick_prescaler
    import lock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/lock_phase_timer.sv
// Lock chamber phase sequencer: runs one of arrive / fill-and-pressurize / evacuate at a time
// and counts elapsed seconds for each; the counts feed the 7-seg display decoder directly.
module lock_phase_timer
    import lock_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int ARRIVE_MAX = 4,
    parameter int FANDP_MAX  = 7,
    parameter int EVAC_MAX   = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                arriveReq,
    input  logic                fillReq,
    input  logic                evacReq,
    output logic [ARRIVE_W-1:0] countArrive,
    output logic [FANDP_W-1:0]  countFandP,
    output logic [EVAC_W-1:0]   countEvacuate,
    output logic [1:0]          phase,
    output logic                busy,
    output logic                done
);

    localparam logic [ARRIVE_W-1:0] A_MAX = ARRIVE_W'(ARRIVE_MAX);
    localparam logic [FANDP_W-1:0]  F_MAX = FANDP_W'(FANDP_MAX);
    localparam logic [EVAC_W-1:0]   E_MAX = EVAC_W'(EVAC_MAX);

    phase_t              state, state_nxt;
    logic                busy_nxt, done_nxt, tick;
    logic [ARRIVE_W-1:0] ca_nxt, ca_inc;
    logic [FANDP_W-1:0]  cf_nxt, cf_inc;
    logic [EVAC_W-1:0]   ce_nxt, ce_inc;

    // Prescaler is held cleared in IDLE so the first tick lands TICK_DIV cycles after entry
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (!busy),
        .en    (busy),
        .tick  (tick)
    );

    assign ca_inc = countArrive   + ARRIVE_W'(1);
    assign cf_inc = countFandP    + FANDP_W'(1);
    assign ce_inc = countEvacuate + EVAC_W'(1);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ca_nxt    = countArrive;
        cf_nxt    = countFandP;
        ce_nxt    = countEvacuate;
        case (state)
            ST_IDLE: begin
                if (arriveReq) begin
                    state_nxt = ST_ARRIVE;
                    ca_nxt    = '0;
                end else if (fillReq) begin
                    state_nxt = ST_FANDP;
                    cf_nxt    = '0;
                end else if (evacReq) begin
                    state_nxt = ST_EVAC;
                    ce_nxt    = '0;
                end
            end
            ST_ARRIVE: if (tick) begin
                ca_nxt = ca_inc;
                if (ca_inc == A_MAX) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ST_FANDP: if (tick) begin
                cf_nxt = cf_inc;
                if (cf_inc == F_MAX) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            ST_EVAC: if (tick) begin
                ce_nxt = ce_inc;
                if (ce_inc == E_MAX) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            countArrive   <= '0;
            countFandP    <= '0;
            countEvacuate <= '0;
        end else begin
            state         <= state_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            countArrive   <= ca_nxt;
            countFandP    <= cf_nxt;
            countEvacuate <= ce_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_lock_phase_timer.sv
// Scoreboard bench for lock_phase_timer with TICK_DIV=4; expected snapshots are keyed by edge number.
module tb_lock_phase_timer;
    import lock_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       arriveReq = 1'b0, fillReq = 1'b0, evacReq = 1'b0;
    logic [2:0] countArrive, countFandP;
    logic [3:0] countEvacuate;
    logic [1:0] phase;
    logic       busy, done;

    lock_phase_timer #(.TICK_DIV(4)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .arriveReq     (arriveReq),
        .fillReq       (fillReq),
        .evacReq       (evacReq),
        .countArrive   (countArrive),
        .countFandP    (countFandP),
        .countEvacuate (countEvacuate),
        .phase         (phase),
        .busy          (busy),
        .done          (done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          e;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   dq[$];
    int   cyc = 0;
    int   vectors = 0;
    int   fails = 0;
    int   e0, e1, e2, e3, e4;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic string fmt(logic [13:0] v);
        return $sformatf("ph=%0d ca=%0d cf=%0d ce=%0d busy=%0d done=%0d",
                         v[13:12], v[11:9], v[8:6], v[5:2], v[1], v[0]);
    endfunction

    function automatic void push(int e, int ph, int ca, int cf, int ce, int b, int d);
        exp_t x;
        x.e = e;
        x.v = {2'(ph), 3'(ca), 3'(cf), 4'(ce), 1'(b), 1'(d)};
        sb.push_back(x);
    endfunction

    task automatic wait_until(int n);
        while (cyc < n) @(negedge Clock);
    endtask

    // Monitor: snapshot scoreboard plus done-pulse scoreboard
    always @(negedge Clock) begin
        logic [13:0] act;
        act = {phase, countArrive, countFandP, countEvacuate, busy, done};
        while (sb.size() > 0 && sb[0].e <= cyc) begin
            vectors++;
            if (sb[0].e < cyc || act !== sb[0].v) begin
                fails++;
                $display("FAIL snap@edge%0d got %s required %s", sb[0].e, fmt(act), fmt(sb[0].v));
            end
            void'(sb.pop_front());
        end
        if (done === 1'b1) begin
            vectors++;
            if (dq.size() == 0 || dq[0] != cyc) begin
                fails++;
                $display("FAIL done_pulse got done=1 at edge%0d required edge%0d",
                         cyc, (dq.size() > 0) ? dq[0] : -1);
            end else begin
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held over edges 1 and 2
        push(2, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Arrive run
        arriveReq = 1'b1;
        e0 = cyc + 1;
        push(e0,      1, 0, 0, 0, 1, 0);
        push(e0 + 4,  1, 1, 0, 0, 1, 0);
        push(e0 + 15, 1, 3, 0, 0, 1, 0);
        push(e0 + 16, 0, 4, 0, 0, 0, 1);
        push(e0 + 17, 0, 4, 0, 0, 0, 0);
        dq.push_back(e0 + 16);
        @(negedge Clock);
        arriveReq = 1'b0;
        wait_until(e0 + 18);

        // Fill and evac together: fill wins, held evac follows immediately
        fillReq = 1'b1;
        evacReq = 1'b1;
        e1 = cyc + 1;
        push(e1,      2, 4, 0, 0, 1, 0);
        push(e1 + 4,  2, 4, 1, 0, 1, 0);
        push(e1 + 28, 0, 4, 7, 0, 0, 1);
        push(e1 + 29, 3, 4, 7, 0, 1, 0);
        push(e1 + 45, 3, 4, 7, 4, 1, 0);
        push(e1 + 61, 0, 4, 7, 8, 0, 1);
        push(e1 + 62, 0, 4, 7, 8, 0, 0);
        dq.push_back(e1 + 28);
        dq.push_back(e1 + 61);
        @(negedge Clock);
        fillReq = 1'b0;
        wait_until(e1 + 29);
        evacReq = 1'b0;
        wait_until(e1 + 63);

        // Evac request during arrive is ignored and dropped before arrive ends
        arriveReq = 1'b1;
        e2 = cyc + 1;
        push(e2,      1, 0, 7, 8, 1, 0);
        push(e2 + 8,  1, 2, 7, 8, 1, 0);
        push(e2 + 16, 0, 4, 7, 8, 0, 1);
        push(e2 + 17, 0, 4, 7, 8, 0, 0);
        push(e2 + 18, 0, 4, 7, 8, 0, 0);
        dq.push_back(e2 + 16);
        @(negedge Clock);
        arriveReq = 1'b0;
        wait_until(e2 + 2);
        evacReq = 1'b1;
        wait_until(e2 + 10);
        evacReq = 1'b0;
        wait_until(e2 + 18);

        // Back-to-back evac runs; count restarts at 0 and tops out at 8
        evacReq = 1'b1;
        e3 = cyc + 1;
        push(e3,      3, 4, 7, 0, 1, 0);
        push(e3 + 31, 3, 4, 7, 7, 1, 0);
        push(e3 + 32, 0, 4, 7, 8, 0, 1);
        push(e3 + 33, 3, 4, 7, 0, 1, 0);
        push(e3 + 65, 0, 4, 7, 8, 0, 1);
        push(e3 + 66, 0, 4, 7, 8, 0, 0);
        push(e3 + 70, 0, 4, 7, 8, 0, 0);
        dq.push_back(e3 + 32);
        dq.push_back(e3 + 65);
        wait_until(e3 + 33);
        evacReq = 1'b0;
        wait_until(e3 + 71);

        // Reset mid-evac at count 5: everything clears, no done
        evacReq = 1'b1;
        e4 = cyc + 1;
        push(e4,      3, 4, 7, 0, 1, 0);
        push(e4 + 20, 3, 4, 7, 5, 1, 0);
        push(e4 + 21, 3, 4, 7, 5, 1, 0);
        push(e4 + 22, 0, 0, 0, 0, 0, 0);
        push(e4 + 26, 0, 0, 0, 0, 0, 0);
        @(negedge Clock);
        evacReq = 1'b0;
        wait_until(e4 + 21);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        wait_until(e4 + 28);

        while (sb.size() > 0) begin
            vectors++;
            fails++;
            $display("FAIL snap@edge%0d got unchecked required checked", sb[0].e);
            void'(sb.pop_front());
        end
        while (dq.size() > 0) begin
            vectors++;
            fails++;
            $display("FAIL done_pulse got none required edge%0d", dq[0]);
            void'(dq.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
